// File: rtl/geri_yaz_hakem.sv
// Register-file write-port arbiter: shares one write port between the in-order
// pipeline writeback and a single-entry buffer holding a long-latency (divider) result.
module geri_yaz_hakem #(
    parameter int ACLIK_SINIRI = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        yrt_gecerli_i,
    input  logic        yrt_yaz_i,
    input  logic [4:0]  yrt_rd_adres_i,
    input  logic [31:0] yrt_rd_deger_i,
    output logic        yrt_durdur_o,
    input  logic        uzun_gecerli_i,
    input  logic [4:0]  uzun_adres_i,
    input  logic [31:0] uzun_deger_i,
    output logic        uzun_hazir_o,
    output logic [4:0]  cyo_yaz_adres_o,
    output logic [31:0] cyo_yaz_deger_o,
    output logic        cyo_yaz_yazmac_o
);

    typedef enum logic [1:0] {
        BOS   = 2'd0,
        BEKLE = 2'd1,
        ZORLA = 2'd2
    } durum_t;

    localparam logic [2:0] SINIR = 3'(ACLIK_SINIRI);

    durum_t      durum_q, durum_d;
    logic [4:0]  tampon_adres_q, tampon_adres_d;
    logic [31:0] tampon_deger_q, tampon_deger_d;
    logic [2:0]  kayip_q, kayip_d;
    logic [2:0]  kayip_artan;

    logic [4:0]  cyo_adres_q, cyo_adres_d;
    logic [31:0] cyo_deger_q, cyo_deger_d;
    logic        cyo_yaz_q, cyo_yaz_d;

    logic        yrt_istek;
    logic        yrt_izin;
    logic        tampon_izin;

    // Loss counter never wraps, so a long run of lost cycles cannot hide a forced grant.
    function automatic logic [2:0] kayip_artir(input logic [2:0] k);
        return (k == 3'd7) ? k : k + 3'd1;
    endfunction

    assign yrt_istek   = yrt_gecerli_i & yrt_yaz_i & (yrt_rd_adres_i != 5'd0);
    assign yrt_izin    = yrt_istek & (durum_q != ZORLA);
    assign tampon_izin = (durum_q == ZORLA) | ((durum_q == BEKLE) & ~yrt_istek);
    assign kayip_artan = kayip_artir(kayip_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum_q <= BOS;
            kayip_q <= 3'd0;
        end else begin
            durum_q <= durum_d;
            kayip_q <= kayip_d;
        end
    end

    // Buffer contents are qualified by the state, so they need no reset.
    always_ff @(posedge clk_i) begin
        tampon_adres_q <= tampon_adres_d;
        tampon_deger_q <= tampon_deger_d;
    end

    always_comb begin
        durum_d        = durum_q;
        tampon_adres_d = tampon_adres_q;
        tampon_deger_d = tampon_deger_q;
        kayip_d        = kayip_q;
        case (durum_q)
            BOS: begin
                // A divider result aimed at x0 is acknowledged and dropped here.
                if (uzun_gecerli_i && (uzun_adres_i != 5'd0)) begin
                    tampon_adres_d = uzun_adres_i;
                    tampon_deger_d = uzun_deger_i;
                    kayip_d        = 3'd0;
                    durum_d        = BEKLE;
                end
            end
            BEKLE: begin
                if (yrt_istek) begin
                    // A younger pipeline write to the same register makes the buffered value dead.
                    if (yrt_rd_adres_i == tampon_adres_q) begin
                        durum_d = BOS;
                    end else begin
                        kayip_d = kayip_artan;
                        if (kayip_artan == SINIR) begin
                            durum_d = ZORLA;
                        end
                    end
                end else begin
                    durum_d = BOS;
                end
            end
            ZORLA: begin
                durum_d = BOS;
            end
            default: begin
                durum_d = BOS;
            end
        endcase
    end

    always_comb begin
        uzun_hazir_o = (durum_q == BOS);
        yrt_durdur_o = (durum_q == ZORLA);
        cyo_yaz_d    = 1'b0;
        cyo_adres_d  = 5'd0;
        cyo_deger_d  = 32'd0;
        if (yrt_izin) begin
            cyo_yaz_d   = 1'b1;
            cyo_adres_d = yrt_rd_adres_i;
            cyo_deger_d = yrt_rd_deger_i;
        end else if (tampon_izin) begin
            cyo_yaz_d   = 1'b1;
            cyo_adres_d = tampon_adres_q;
            cyo_deger_d = tampon_deger_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cyo_yaz_q   <= 1'b0;
            cyo_adres_q <= 5'd0;
            cyo_deger_q <= 32'd0;
        end else begin
            cyo_yaz_q   <= cyo_yaz_d;
            cyo_adres_q <= cyo_adres_d;
            cyo_deger_q <= cyo_deger_d;
        end
    end

    assign cyo_yaz_yazmac_o = cyo_yaz_q;
    assign cyo_yaz_adres_o  = cyo_adres_q;
    assign cyo_yaz_deger_o  = cyo_deger_q;

endmodule

// File: tb/tb_geri_yaz_hakem.sv
// Directed bench for geri_yaz_hakem: expected register-file writes are queued with
// the cycle they must appear in and compared against the write port every cycle.
module tb_geri_yaz_hakem;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        yrt_gecerli_i, yrt_yaz_i;
    logic [4:0]  yrt_rd_adres_i;
    logic [31:0] yrt_rd_deger_i;
    logic        yrt_durdur_o;
    logic        uzun_gecerli_i;
    logic [4:0]  uzun_adres_i;
    logic [31:0] uzun_deger_i;
    logic        uzun_hazir_o;
    logic [4:0]  cyo_yaz_adres_o;
    logic [31:0] cyo_yaz_deger_o;
    logic        cyo_yaz_yazmac_o;

    geri_yaz_hakem #(.ACLIK_SINIRI(4)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .yrt_gecerli_i    (yrt_gecerli_i),
        .yrt_yaz_i        (yrt_yaz_i),
        .yrt_rd_adres_i   (yrt_rd_adres_i),
        .yrt_rd_deger_i   (yrt_rd_deger_i),
        .yrt_durdur_o     (yrt_durdur_o),
        .uzun_gecerli_i   (uzun_gecerli_i),
        .uzun_adres_i     (uzun_adres_i),
        .uzun_deger_i     (uzun_deger_i),
        .uzun_hazir_o     (uzun_hazir_o),
        .cyo_yaz_adres_o  (cyo_yaz_adres_o),
        .cyo_yaz_deger_o  (cyo_yaz_deger_o),
        .cyo_yaz_yazmac_o (cyo_yaz_yazmac_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          cyc;
        logic [4:0]  adr;
        logic [31:0] val;
    } beklenen_t;

    beklenen_t sb[$];
    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input int c, input logic [4:0] adr, input logic [31:0] val);
        beklenen_t e;
        e.cyc = c;
        e.adr = adr;
        e.val = val;
        sb.push_back(e);
    endtask

    // Advance one edge, then compare the write port with the scoreboard head.
    task automatic tick();
        beklenen_t e;
        @(posedge clk_i);
        cyc++;
        #1;
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            chk($sformatf("yaz_en@%0d", cyc), cyo_yaz_yazmac_o, 1);
            chk($sformatf("yaz_adr@%0d", cyc), cyo_yaz_adres_o, e.adr);
            chk($sformatf("yaz_val@%0d", cyc), cyo_yaz_deger_o, e.val);
        end else begin
            chk($sformatf("bos_en@%0d", cyc), cyo_yaz_yazmac_o, 0);
            chk($sformatf("bos_adr@%0d", cyc), cyo_yaz_adres_o, 0);
            chk($sformatf("bos_val@%0d", cyc), cyo_yaz_deger_o, 0);
        end
    endtask

    task automatic set_yrt(input logic g, input logic y, input logic [4:0] adr, input logic [31:0] val);
        yrt_gecerli_i  = g;
        yrt_yaz_i      = y;
        yrt_rd_adres_i = adr;
        yrt_rd_deger_i = val;
    endtask

    task automatic set_uzun(input logic g, input logic [4:0] adr, input logic [31:0] val);
        uzun_gecerli_i = g;
        uzun_adres_i   = adr;
        uzun_deger_i   = val;
    endtask

    task automatic idle();
        set_yrt(0, 0, 5'd0, 32'd0);
        set_uzun(0, 5'd0, 32'd0);
    endtask

    initial begin
        // Reset with live requests that must be ignored.
        rst_i = 1'b1;
        set_yrt(1, 1, 5'd5, 32'hDEAD_BEEF);
        set_uzun(1, 5'd7, 32'hCAFE_F00D);
        tick();
        chk("rst_hazir", uzun_hazir_o, 1);
        chk("rst_durdur", yrt_durdur_o, 0);
        rst_i = 1'b0;
        idle();
        tick();
        chk("post_rst_hazir", uzun_hazir_o, 1);

        // Pipeline write with empty buffer: one-cycle latency.
        set_yrt(1, 1, 5'd6, 32'h0000_FFFF);
        push(cyc + 1, 5'd6, 32'h0000_FFFF);
        tick();
        idle();
        tick();

        // Divider result alone: written two cycles after transfer.
        chk("hazir_before_xfer", uzun_hazir_o, 1);
        set_uzun(1, 5'd9, 32'hFFFF_0000);
        push(cyc + 2, 5'd9, 32'hFFFF_0000);
        tick();
        idle();
        chk("hazir_in_bekle", uzun_hazir_o, 0);
        chk("durdur_in_bekle", yrt_durdur_o, 0);
        tick();
        chk("hazir_back", uzun_hazir_o, 1);
        tick();

        // Same-address pipeline write supersedes the buffered value.
        set_uzun(1, 5'd9, 32'hFFFF_0000);
        tick();
        set_uzun(0, 5'd0, 32'd0);
        set_yrt(1, 1, 5'd9, 32'h1234_5678);
        push(cyc + 1, 5'd9, 32'h1234_5678);
        tick();
        idle();
        chk("hazir_after_kill", uzun_hazir_o, 1);
        tick();
        tick();

        // Four lost cycles force a one-cycle stall and a buffer grant.
        set_uzun(1, 5'd9, 32'hFFFF_0000);
        tick();
        set_uzun(0, 5'd0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            set_yrt(1, 1, 5'd3, 32'h3000_0000 + 32'(i));
            push(cyc + 1, 5'd3, 32'h3000_0000 + 32'(i));
            chk($sformatf("durdur_loss%0d", i), yrt_durdur_o, 0);
            tick();
        end
        set_yrt(1, 1, 5'd3, 32'h3000_0004);
        chk("durdur_zorla", yrt_durdur_o, 1);
        chk("hazir_zorla", uzun_hazir_o, 0);
        push(cyc + 1, 5'd9, 32'hFFFF_0000);
        tick();
        chk("durdur_one_cycle", yrt_durdur_o, 0);
        push(cyc + 1, 5'd3, 32'h3000_0004);
        tick();
        idle();
        tick();

        // Three losses stay below the limit; the idle cycle drains the buffer.
        set_uzun(1, 5'd12, 32'hA5A5_5A5A);
        tick();
        set_uzun(0, 5'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            set_yrt(1, 1, 5'd4, 32'h4000_0000 + 32'(i));
            push(cyc + 1, 5'd4, 32'h4000_0000 + 32'(i));
            tick();
            chk($sformatf("durdur_below%0d", i), yrt_durdur_o, 0);
        end
        idle();
        push(cyc + 1, 5'd12, 32'hA5A5_5A5A);
        tick();
        chk("hazir_after_drain", uzun_hazir_o, 1);

        // Pipeline and divider in the same cycle: pipeline first, buffer next.
        set_yrt(1, 1, 5'd20, 32'h2020_2020);
        set_uzun(1, 5'd21, 32'h2121_2121);
        push(cyc + 1, 5'd20, 32'h2020_2020);
        push(cyc + 2, 5'd21, 32'h2121_2121);
        tick();
        idle();
        tick();
        tick();

        // Writes to x0 from either source never reach the port.
        set_uzun(1, 5'd0, 32'h0BAD_0BAD);
        tick();
        chk("hazir_after_x0", uzun_hazir_o, 1);
        set_uzun(0, 5'd0, 32'd0);
        set_yrt(1, 1, 5'd0, 32'h0BAD_0BAD);
        tick();
        chk("hazir_after_rd0", uzun_hazir_o, 1);
        set_yrt(1, 0, 5'd5, 32'h5555_5555);
        tick();
        idle();
        tick();

        // Reset while the buffer is full drops the entry.
        set_uzun(1, 5'd9, 32'hFFFF_0000);
        tick();
        idle();
        chk("hazir_bekle_pre_rst", uzun_hazir_o, 0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("hazir_mid_rst", uzun_hazir_o, 1);
        chk("durdur_mid_rst", yrt_durdur_o, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
        end

        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
